// File: rtl/typed_cmd_pkg.sv
// Shared types for the typed command queue: command kinds, sequencer states,
// default field widths and the kind-legality check.
// Build option: TYPED_CMD_QUEUE_STATS_EN adds popped BURST/NOP counters to the top.
package typed_cmd_pkg;

    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_LEN_W  = 4;
    localparam int unsigned DEF_DEPTH  = 4;

    typedef enum logic [2:0] {
        KIND_NOP   = 3'd0,
        KIND_READ  = 3'd1,
        KIND_WRITE = 3'd2,
        KIND_BURST = 3'd4
    } kind_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT  = 2'd1,
        S_BURST = 2'd2
    } state_t;

    // Only the four encoded kinds are accepted into the queue
    function automatic logic kind_is_legal(input logic [2:0] k);
        case (k)
            KIND_NOP, KIND_READ, KIND_WRITE, KIND_BURST: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/typed_cmd_queue_if.sv
// Command-in / beat-out handshake bundle for typed_cmd_queue.
// master = producer/consumer side, slave = the queue.
interface typed_cmd_queue_if
    import typed_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned LEN_W  = DEF_LEN_W
);
    logic              i_valid;
    logic              o_ready;
    logic [2:0]        i_kind;
    logic [ADDR_W-1:0] i_addr;
    logic [LEN_W-1:0]  i_len;
    logic              o_valid;
    logic              i_ready;
    logic [2:0]        o_kind;
    logic [ADDR_W-1:0] o_addr;
    logic              o_last;

    modport master (
        output i_valid, i_kind, i_addr, i_len, i_ready,
        input  o_ready, o_valid, o_kind, o_addr, o_last
    );

    modport slave (
        input  i_valid, i_kind, i_addr, i_len, i_ready,
        output o_ready, o_valid, o_kind, o_addr, o_last
    );
endinterface

// File: rtl/typed_cmd_fifo.sv
// DEPTH-entry synchronous FIFO holding packed command records, with occupancy.
// Push when full and pop when empty are ignored.
module typed_cmd_fifo
    import typed_cmd_pkg::*;
#(
    parameter int unsigned WIDTH = 3 + DEF_ADDR_W + DEF_LEN_W,
    parameter int unsigned DEPTH = DEF_DEPTH
)
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array; contents are only meaningful between the pointers
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/typed_cmd_queue.sv
// Typed command queue: buffers {kind, addr, len} records and replays them as
// single beats (READ/WRITE) or address-incrementing bursts (BURST); NOPs are
// consumed silently, illegal kinds are dropped and flagged on sticky o_err.
// Build option: TYPED_CMD_QUEUE_STATS_EN adds o_burst_cnt / o_nop_cnt.
module typed_cmd_queue
    import typed_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned LEN_W  = DEF_LEN_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
)
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    typed_cmd_queue_if.slave        bus,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_err
`ifdef TYPED_CMD_QUEUE_STATS_EN
    ,
    output logic [7:0]              o_burst_cnt,
    output logic [7:0]              o_nop_cnt
`endif
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        kind_t             kind;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

    cmd_t              w_push_cmd;
    cmd_t              w_head;
    logic [CMD_W-1:0]  w_head_raw;
    logic [CNT_W-1:0]  w_count;
    logic              w_empty;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;

    state_t            r_state;
    kind_t             r_kind;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_valid;
    logic              r_last;
    logic              r_err;

    assign w_accept   = bus.i_valid && bus.o_ready;
    assign w_push     = w_accept && kind_is_legal(bus.i_kind);
    assign w_pop      = (r_state == S_IDLE) && !w_empty;
    assign w_push_cmd = '{kind: kind_t'(bus.i_kind), addr: bus.i_addr, len: bus.i_len};
    assign w_head     = cmd_t'(w_head_raw);

    typed_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (CMD_W'(w_push_cmd)),
        .i_pop   (w_pop),
        .o_data  (w_head_raw),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    // Sequencer: pop head in IDLE, then hold each beat until the consumer takes it
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_kind  <= KIND_NOP;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        case (w_head.kind)
                            KIND_READ, KIND_WRITE: begin
                                r_state <= S_BEAT;
                                r_kind  <= w_head.kind;
                                r_addr  <= w_head.addr;
                                r_valid <= 1'b1;
                                r_last  <= 1'b1;
                            end
                            KIND_BURST: begin
                                r_state <= S_BURST;
                                r_kind  <= w_head.kind;
                                r_addr  <= w_head.addr;
                                r_cnt   <= w_head.len;
                                r_valid <= 1'b1;
                                r_last  <= (w_head.len == '0);
                            end
                            default: begin
                                r_state <= S_IDLE;
                            end
                        endcase
                    end
                end
                S_BEAT: begin
                    if (bus.i_ready) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                    end
                end
                S_BURST: begin
                    if (bus.i_ready) begin
                        if (r_cnt == '0) begin
                            r_state <= S_IDLE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                        end else begin
                            r_cnt  <= r_cnt - LEN_W'(1);
                            r_addr <= r_addr + ADDR_W'(1);
                            r_last <= (r_cnt == LEN_W'(1));
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flag for any handshake carrying an illegal kind
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_err <= 1'b0;
        end else if (w_accept && !kind_is_legal(bus.i_kind)) begin
            r_err <= 1'b1;
        end
    end

`ifdef TYPED_CMD_QUEUE_STATS_EN
    logic [7:0] r_burst_cnt;
    logic [7:0] r_nop_cnt;

    // Saturating counts of popped BURST and NOP commands
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_burst_cnt <= '0;
            r_nop_cnt   <= '0;
        end else if (w_pop) begin
            if (w_head.kind == KIND_BURST && r_burst_cnt != 8'hFF) begin
                r_burst_cnt <= r_burst_cnt + 8'd1;
            end
            if (w_head.kind == KIND_NOP && r_nop_cnt != 8'hFF) begin
                r_nop_cnt <= r_nop_cnt + 8'd1;
            end
        end
    end

    assign o_burst_cnt = r_burst_cnt;
    assign o_nop_cnt   = r_nop_cnt;
`endif

    assign bus.o_ready = (w_count != CNT_W'(DEPTH));
    assign bus.o_valid = r_valid;
    assign bus.o_kind  = r_kind;
    assign bus.o_addr  = r_addr;
    assign bus.o_last  = r_last;
    assign o_count     = w_count;
    assign o_err       = r_err;

endmodule

// File: tb/tb_typed_cmd_queue.sv
// Directed bench for typed_cmd_queue: a cycle table for single beats, a
// wrapping burst with back-pressure and illegal/NOP filtering, then hand
// sequences for fill/drain and reset mid-burst.
module tb_typed_cmd_queue;

    logic       clk;
    logic       rst_n;
    logic [2:0] count;
    logic       err;

    int n_vec = 0;
    int n_bad = 0;

    typed_cmd_queue_if #(.ADDR_W(10), .LEN_W(4)) bus ();

    typed_cmd_queue #(
        .ADDR_W (10),
        .LEN_W  (4),
        .DEPTH  (4)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst_n),
        .bus     (bus),
        .o_count (count),
        .o_err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       in_valid;
        logic [2:0] in_kind;
        logic [9:0] in_addr;
        logic [3:0] in_len;
        logic       in_rdy;
        logic       e_valid;
        logic [2:0] e_kind;
        logic [9:0] e_addr;
        logic       e_last;
        logic [2:0] e_count;
        logic       e_err;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic logic [31:0] pack(input logic v, input logic [2:0] k,
                                         input logic [9:0] a, input logic l,
                                         input logic [2:0] c, input logic r,
                                         input logic e);
        return {12'd0, v, k, a, l, c, r, e};
    endfunction

    function automatic logic [31:0] dut_state();
        return pack(bus.o_valid, bus.o_kind, bus.o_addr, bus.o_last,
                    count, bus.o_ready, err);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] k, input logic [9:0] a,
                         input logic [3:0] l, input logic r);
        bus.i_valid = v;
        bus.i_kind  = k;
        bus.i_addr  = a;
        bus.i_len   = l;
        bus.i_ready = r;
    endtask

    logic [9:0] exp_addrs [5];
    logic [9:0] got_addrs [5];
    int         n_seen;

    initial begin
        // Fields: in_valid, in_kind, in_addr, in_len, in_rdy | valid, kind, addr, last, count, err
        // READ @5: written on first edge, loaded as a beat on the second
        vecs[0]  = '{1'b1, 3'd1, 10'd5,    4'd0, 1'b1, 1'b0, 3'd0, 10'd0,    1'b0, 3'd1, 1'b0};
        vecs[1]  = '{1'b0, 3'd0, 10'd0,    4'd0, 1'b1, 1'b1, 3'd1, 10'd5,    1'b1, 3'd0, 1'b0};
        vecs[2]  = '{1'b0, 3'd0, 10'd0,    4'd0, 1'b1, 1'b0, 3'd1, 10'd5,    1'b0, 3'd0, 1'b0};
        // BURST @1022 len 3 with ready toggling: 1022, 1023, 0, 1(last)
        vecs[3]  = '{1'b1, 3'd4, 10'd1022, 4'd3, 1'b0, 1'b0, 3'd1, 10'd5,    1'b0, 3'd1, 1'b0};
        vecs[4]  = '{1'b0, 3'd0, 10'd0,    4'd0, 1'b0, 1'b1, 3'd4, 10'd1022, 1'b0, 3'd0, 1'b0};
        vecs[5]  = '{1'b0, 3'd0, 10'd0,    4'd0, 1'b0, 1'b1, 3'd4, 10'd1022, 1'b0, 3'd0, 1'b0};
        vecs[6]  = '{1'b0, 3'd0, 10'd0,    4'd0, 1'b1, 1'b1, 3'd4, 10'd1023, 1'b0, 3'd0, 1'b0};
        vecs[7]  = '{1'b0, 3'd0, 10'd0,    4'd0, 1'b0, 1'b1, 3'd4, 10'd1023, 1'b0, 3'd0, 1'b0};
        vecs[8]  = '{1'b0, 3'd0, 10'd0,    4'd0, 1'b1, 1'b1, 3'd4, 10'd0,    1'b0, 3'd0, 1'b0};
        vecs[9]  = '{1'b0, 3'd0, 10'd0,    4'd0, 1'b1, 1'b1, 3'd4, 10'd1,    1'b1, 3'd0, 1'b0};
        vecs[10] = '{1'b0, 3'd0, 10'd0,    4'd0, 1'b0, 1'b1, 3'd4, 10'd1,    1'b1, 3'd0, 1'b0};
        vecs[11] = '{1'b0, 3'd0, 10'd0,    4'd0, 1'b1, 1'b0, 3'd4, 10'd1,    1'b0, 3'd0, 1'b0};
        // Illegal kind 3 dropped, NOP stored then silently popped, WRITE @7 beats
        vecs[12] = '{1'b1, 3'd3, 10'd9,    4'd0, 1'b1, 1'b0, 3'd4, 10'd1,    1'b0, 3'd0, 1'b1};
        vecs[13] = '{1'b1, 3'd0, 10'd0,    4'd0, 1'b1, 1'b0, 3'd4, 10'd1,    1'b0, 3'd1, 1'b1};
        vecs[14] = '{1'b1, 3'd2, 10'd7,    4'd0, 1'b1, 1'b0, 3'd4, 10'd1,    1'b0, 3'd1, 1'b1};
        vecs[15] = '{1'b0, 3'd0, 10'd0,    4'd0, 1'b1, 1'b1, 3'd2, 10'd7,    1'b1, 3'd0, 1'b1};
        vecs[16] = '{1'b0, 3'd0, 10'd0,    4'd0, 1'b1, 1'b0, 3'd2, 10'd7,    1'b0, 3'd0, 1'b1};
        vecs[17] = '{1'b0, 3'd0, 10'd0,    4'd0, 1'b1, 1'b0, 3'd2, 10'd7,    1'b0, 3'd0, 1'b1};

        exp_addrs[0] = 10'd10;
        exp_addrs[1] = 10'd11;
        exp_addrs[2] = 10'd12;
        exp_addrs[3] = 10'd13;
        exp_addrs[4] = 10'd14;

        // Reset and idle state
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 10'd0, 4'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", dut_state(), pack(1'b0, 3'd0, 10'd0, 1'b0, 3'd0, 1'b1, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", dut_state(), pack(1'b0, 3'd0, 10'd0, 1'b0, 3'd0, 1'b1, 1'b0));

        // Cycle table
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].in_valid, vecs[i].in_kind, vecs[i].in_addr, vecs[i].in_len, vecs[i].in_rdy);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), dut_state(),
                  pack(vecs[i].e_valid, vecs[i].e_kind, vecs[i].e_addr, vecs[i].e_last,
                       vecs[i].e_count, (vecs[i].e_count != 3'd4), vecs[i].e_err));
        end

        // Fill: with ready low the first WRITE parks in the output stage,
        // the next four fill the FIFO
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'd2, 10'(10 + i), 4'd0, 1'b0);
            @(posedge clk);
            #1;
        end
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(bus.o_ready), 32'd0);
        check("full_head_beat", dut_state(), pack(1'b1, 3'd2, 10'd10, 1'b1, 3'd4, 1'b0, 1'b1));
        drive(1'b1, 3'd2, 10'd99, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        check("push_when_full_ignored", 32'(count), 32'd4);

        // Drain with ready high; each sampled valid cycle is a distinct beat
        drive(1'b0, 3'd0, 10'd0, 4'd0, 1'b1);
        n_seen = 0;
        for (int c = 0; c < 40 && n_seen < 5; c++) begin
            if (bus.o_valid) begin
                got_addrs[n_seen] = bus.o_addr;
                n_seen++;
            end
            @(posedge clk);
            #1;
        end
        check("drain_beats", 32'(n_seen), 32'd5);
        for (int i = 0; i < n_seen; i++) begin
            check($sformatf("drain_addr%0d", i), 32'(got_addrs[i]), 32'(exp_addrs[i]));
        end
        repeat (2) @(posedge clk);
        #1;
        check("drained_state", dut_state(), pack(1'b0, 3'd2, 10'd14, 1'b0, 3'd0, 1'b1, 1'b1));

        // Reset during beat 2 of an 8-beat burst
        drive(1'b1, 3'd4, 10'd100, 4'd7, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 3'd0, 10'd0, 4'd0, 1'b1);
        @(posedge clk);
        #1;
        check("rst_burst_beat1", dut_state(), pack(1'b1, 3'd4, 10'd100, 1'b0, 3'd0, 1'b1, 1'b1));
        @(posedge clk);
        #1;
        check("rst_burst_beat2", dut_state(), pack(1'b1, 3'd4, 10'd101, 1'b0, 3'd0, 1'b1, 1'b1));
        rst_n = 1'b0;
        #1;
        check("async_reset_values", dut_state(), pack(1'b0, 3'd0, 10'd0, 1'b0, 3'd0, 1'b1, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        n_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (bus.o_valid) n_seen++;
        end
        check("no_beats_after_reset", 32'(n_seen), 32'd0);
        check("post_reset_idle", dut_state(), pack(1'b0, 3'd0, 10'd0, 1'b0, 3'd0, 1'b1, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
